// File: rtl/perceptron_layer_sequencer.sv
// perceptron_layer_sequencer: time-multiplexes one perceptron PE across the M neurons of a layer.
// Streams one weight row per cycle into the PE and gathers the tagged results into a vector.
module perceptron_layer_sequencer #(
    parameter int N          = 4,
    parameter int M          = 4,
    parameter int DATA_WIDTH = 16,
    parameter int PE_LATENCY = 1,
    parameter int ADDR_WIDTH = (M > 1) ? $clog2(M) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_in_valid,
    output logic                            o_in_ready,
    input  logic [N-1:0][DATA_WIDTH-1:0]    i_in_x,
    output logic                            o_mem_rd_en,
    output logic [ADDR_WIDTH-1:0]           o_mem_addr,
    input  logic [N-1:0][DATA_WIDTH-1:0]    i_mem_w,
    input  logic [DATA_WIDTH-1:0]           i_mem_b,
    output logic [N-1:0][DATA_WIDTH-1:0]    o_pe_x,
    output logic [N-1:0][DATA_WIDTH-1:0]    o_pe_w,
    output logic [DATA_WIDTH-1:0]           o_pe_b,
    input  logic [DATA_WIDTH-1:0]           i_pe_y,
    output logic                            o_out_valid,
    input  logic                            i_out_ready,
    output logic [M-1:0][DATA_WIDTH-1:0]    o_out_y,
    output logic                            o_busy
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]                                r_state;
    logic [ADDR_WIDTH-1:0]                     r_issue_cnt;
    logic                                      r_s1_vld;
    logic [ADDR_WIDTH-1:0]                     r_s1_idx;
    logic [PE_LATENCY-1:0]                     r_d_vld;
    logic [PE_LATENCY-1:0][ADDR_WIDTH-1:0]     r_d_idx;
    logic [N-1:0][DATA_WIDTH-1:0]              r_x;
    logic [M-1:0][DATA_WIDTH-1:0]              r_y_buf;

    logic       w_accept;
    logic       w_last_issue;
    logic       w_cap;
    logic       w_cap_last;
    logic [1:0] w_next_state;

    assign w_accept     = (r_state == S_IDLE) && i_in_valid;
    assign w_last_issue = r_issue_cnt == ADDR_WIDTH'(M - 1);
    assign w_cap        = r_d_vld[PE_LATENCY-1];
    assign w_cap_last   = w_cap && (r_d_idx[PE_LATENCY-1] == ADDR_WIDTH'(M - 1));
    assign w_next_state = (r_state == S_IDLE)  ? (w_accept ? S_RUN : S_IDLE) :
                          (r_state == S_RUN)   ? (w_last_issue ? S_DRAIN : S_RUN) :
                          (r_state == S_DRAIN) ? (w_cap_last ? S_DONE : S_DRAIN) :
                          (i_out_ready ? S_IDLE : S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_issue_cnt <= '0;
            r_s1_vld    <= 1'b0;
            r_s1_idx    <= '0;
            r_d_vld     <= '0;
            r_d_idx     <= '0;
            r_x         <= '0;
            r_y_buf     <= '0;
        end else begin
            r_state  <= w_next_state;
            r_s1_vld <= o_mem_rd_en;
            r_s1_idx <= o_mem_addr;
            // Tag rides alongside the PE pipeline so each result lands in its neuron slot.
            r_d_vld[0] <= r_s1_vld;
            r_d_idx[0] <= r_s1_idx;
            for (int i = PE_LATENCY - 1; i > 0; i--) begin
                r_d_vld[i] <= r_d_vld[i-1];
                r_d_idx[i] <= r_d_idx[i-1];
            end
            if (w_cap) r_y_buf[r_d_idx[PE_LATENCY-1]] <= i_pe_y;
            if (w_accept) begin
                r_x         <= i_in_x;
                r_issue_cnt <= '0;
            end
            if (r_state == S_RUN) r_issue_cnt <= r_issue_cnt + 1'b1;
        end
    end

    assign o_in_ready  = r_state == S_IDLE;
    assign o_busy      = r_state != S_IDLE;
    assign o_mem_rd_en = r_state == S_RUN;
    assign o_mem_addr  = o_mem_rd_en ? r_issue_cnt : '0;
    assign o_pe_x      = r_x;
    assign o_pe_w      = r_s1_vld ? i_mem_w : '0;
    assign o_pe_b      = r_s1_vld ? i_mem_b : '0;
    assign o_out_valid = r_state == S_DONE;
    assign o_out_y     = r_y_buf;
endmodule

// File: tb/tb_perceptron_layer_sequencer.sv
// tb_perceptron_layer_sequencer: three layer configurations run side by side against a
// weight-memory model, a registered PE stub and a dot-product reference.
module tb_perceptron_layer_sequencer;
    localparam int N  = 4;
    localparam int DW = 16;

    logic clk;
    int   n_chk  = 0;
    int   n_pass = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int MM = (g == 0) ? 3 : (g == 1) ? 1 : 5;
        localparam int LL = (g == 2) ? 3 : 1;
        localparam int AW = (MM > 1) ? $clog2(MM) : 1;

        logic                    rst, in_valid, in_ready, mem_rd_en, out_valid, out_ready, busy;
        logic [N-1:0][DW-1:0]    in_x, mem_w, pe_x, pe_w, x_cur;
        logic [AW-1:0]           mem_addr;
        logic [DW-1:0]           mem_b, pe_b, pe_y;
        logic [MM-1:0][DW-1:0]   out_y, exp_y, snap_y;
        logic [DW-1:0]           w_tab [MM][N];
        logic [DW-1:0]           b_tab [MM];
        logic [DW-1:0]           pipe [LL];
        logic [AW-1:0]           rd_log [$];
        bit                      fin = 0;
        string                   pfx = $sformatf("m%0d_l%0d_", MM, LL);

        perceptron_layer_sequencer #(.N(N), .M(MM), .DATA_WIDTH(DW), .PE_LATENCY(LL)) u_dut (
            .clk(clk), .rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_x(in_x),
            .o_mem_rd_en(mem_rd_en), .o_mem_addr(mem_addr), .i_mem_w(mem_w), .i_mem_b(mem_b),
            .o_pe_x(pe_x), .o_pe_w(pe_w), .o_pe_b(pe_b), .i_pe_y(pe_y),
            .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_y(out_y), .o_busy(busy)
        );

        always @(posedge clk) begin
            if (mem_rd_en) begin
                for (int j = 0; j < N; j++) mem_w[j] <= (int'(mem_addr) < MM) ? w_tab[int'(mem_addr) % MM][j] : '0;
                mem_b <= (int'(mem_addr) < MM) ? b_tab[int'(mem_addr) % MM] : '0;
                rd_log.push_back(mem_addr);
            end
        end

        function automatic logic [DW-1:0] pe_calc();
            int s = int'($signed(pe_b));
            for (int j = 0; j < N; j++) s += int'($signed(pe_x[j])) * int'($signed(pe_w[j]));
            return DW'(s);
        endfunction

        always @(posedge clk) begin
            pipe[0] <= pe_calc();
            for (int k = 1; k < LL; k++) pipe[k] <= pipe[k-1];
        end
        assign pe_y = pipe[LL-1];

        function automatic logic [DW-1:0] ref_y(int k);
            int s = int'($signed(b_tab[k]));
            for (int j = 0; j < N; j++) s += int'($signed(x_cur[j])) * int'($signed(w_tab[k][j]));
            return DW'(s);
        endfunction

        task automatic rand_tables();
            for (int k = 0; k < MM; k++) begin
                b_tab[k] = DW'($urandom);
                for (int j = 0; j < N; j++) w_tab[k][j] = DW'($urandom);
            end
        endtask

        task automatic rand_x();
            for (int j = 0; j < N; j++) x_cur[j] = DW'($urandom);
        endtask

        // Called at the negedge of the accept cycle with in_valid already high.
        task automatic expect_result();
            int c = 1;
            rd_log.delete();
            chk({pfx, "accept_ready"}, 128'(in_ready), 128'(1));
            for (int k = 0; k < MM; k++) exp_y[k] = ref_y(k);
            @(negedge clk);
            in_valid = 1'b0;
            while (!out_valid && c < 200) begin
                @(negedge clk);
                c++;
            end
            chk({pfx, "latency"}, 128'(c), 128'(MM + LL + 2));
            for (int k = 0; k < MM; k++) chk($sformatf("%sy%0d", pfx, k), 128'(out_y[k]), 128'(exp_y[k]));
            chk({pfx, "pe_x"}, 128'(pe_x), 128'(x_cur));
            chk({pfx, "reads"}, 128'(rd_log.size()), 128'(MM));
            for (int k = 0; k < rd_log.size(); k++) chk($sformatf("%saddr%0d", pfx, k), 128'(rd_log[k]), 128'(k));
        endtask

        task automatic release_out();
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            chk({pfx, "rel_valid"}, 128'(out_valid), 128'(0));
            chk({pfx, "rel_ready"}, 128'(in_ready), 128'(1));
        endtask

        initial begin
            rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_x = '0; mem_w = '0; mem_b = '0;
            for (int k = 0; k < LL; k++) pipe[k] = '0;
            if (g == 0) begin
                for (int k = 0; k < MM; k++) begin
                    for (int j = 0; j < N; j++) w_tab[k][j] = (k == 0) ? DW'(1) : (k == 1) ? DW'(j == 3) : (j == 0) ? DW'(-1) : DW'(0);
                    b_tab[k] = DW'(k == 1);
                end
                for (int j = 0; j < N; j++) x_cur[j] = DW'(j + 1);
            end else begin
                rand_tables();
                rand_x();
            end
            repeat (3) @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            chk({pfx, "rst_in_ready"}, 128'(in_ready), 128'(1));
            chk({pfx, "rst_out_valid"}, 128'(out_valid), 128'(0));
            chk({pfx, "rst_busy"}, 128'(busy), 128'(0));
            chk({pfx, "rst_rd_en"}, 128'(mem_rd_en), 128'(0));
            chk({pfx, "rst_out_y"}, 128'(out_y), 128'(0));
            chk({pfx, "rst_pe_w"}, 128'(pe_w), 128'(0));
            in_x = x_cur; in_valid = 1'b1;
            expect_result();
            // Backpressure with a stray in_valid pulse that must be ignored.
            for (int h = 0; h < 10; h++) begin
                chk({pfx, "bp_valid"}, 128'(out_valid), 128'(1));
                chk({pfx, "bp_ready"}, 128'(in_ready), 128'(0));
                chk({pfx, "bp_y"}, 128'(out_y), 128'(exp_y));
                in_valid = (h == 3);
                @(negedge clk);
            end
            if (g == 0) begin
                for (int j = 0; j < N; j++) x_cur[j] = (j == 0) ? DW'(2) : DW'(0);
            end else rand_x();
            in_x = x_cur; in_valid = 1'b1; out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            chk({pfx, "b2b_valid"}, 128'(out_valid), 128'(0));
            expect_result();
            release_out();
            snap_y = out_y;
            repeat (LL + 3) @(negedge clk);
            chk({pfx, "idle_y"}, 128'(out_y), 128'(snap_y));
            chk({pfx, "idle_busy"}, 128'(busy), 128'(0));
            chk({pfx, "idle_reads"}, 128'(rd_log.size()), 128'(MM));
            // Reset in the middle of the issue phase.
            rand_tables(); rand_x();
            in_x = x_cur; in_valid = 1'b1;
            rd_log.delete();
            @(negedge clk);
            in_valid = 1'b0;
            repeat (((MM >= 2) ? 2 : 1) - 1) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            chk({pfx, "mid_in_ready"}, 128'(in_ready), 128'(1));
            chk({pfx, "mid_out_valid"}, 128'(out_valid), 128'(0));
            chk({pfx, "mid_rd_en"}, 128'(mem_rd_en), 128'(0));
            chk({pfx, "mid_busy"}, 128'(busy), 128'(0));
            chk({pfx, "mid_reads"}, 128'(rd_log.size()), 128'((MM >= 2) ? 2 : 1));
            repeat (LL + 3) @(negedge clk);
            chk({pfx, "mid_stale_y"}, 128'(out_y), 128'(0));
            for (int t = 0; t < 4; t++) begin
                rand_tables(); rand_x();
                in_x = x_cur; in_valid = 1'b1;
                expect_result();
                repeat ($urandom_range(0, 3)) begin
                    @(negedge clk);
                    chk({pfx, "rnd_hold_y"}, 128'(out_y), 128'(exp_y));
                end
                release_out();
            end
            fin = 1;
        end
    end

    initial begin
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            if (g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin) break;
        end
        chk("all_done", 128'(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin), 128'(1));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
